seq_divider: RTL and testbench

Sequential restoring shift-and-subtract divider: the inverse datapath to the team's shift-and-add multiplier. It uses the same `in_valid`/`busy`/`finish` handshake style so both units plug into the same two-copy constant-time harness. Latency depends on the dividend's magnitude (leading-zero skip) unless `CT_TIME` is set. The unit exposes its control state for cross-copy comparison.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_lzc.sv | 21 ++
 rtl/seq_divider.sv | 144 ++++++++++++++
 tb/tb_seq_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider and its support blocks.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

  // Width of the iteration counter / leading-zero count: must hold 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module div_lzc
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0]            a,
  output logic [cnt_width(WIDTH)-1:0] count
);

  localparam int CW = cnt_width(WIDTH);

  // Scan LSB to MSB so the highest set bit determines the final count.
  always_comb begin
    count = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (a[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first,
// with optional leading-zero skip and a constant-time mode.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH_DEFAULT,
  parameter bit CT_TIME = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            q,
  output logic [WIDTH-1:0]            r,
  output logic                        div_by_zero,
  output logic                        busy,
  output logic                        finish,
  output logic [cnt_width(WIDTH)-1:0] counter
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic             setup_q, setup_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [CW-1:0]    lzc_cnt;
  logic [CW-1:0]    lz;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             take;

  // The count is taken from the latched dividend during the setup cycle.
  div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .a     (dvd_q),
    .count (lzc_cnt)
  );

  assign lz    = CT_TIME ? '0 : lzc_cnt;
  assign trial = {rem_q, dvd_q[WIDTH-1]};
  assign take  = (trial >= {1'b0, dsr_q});
  // trial - divisor always fits in WIDTH bits when take is set.
  assign diff  = trial[WIDTH-1:0] - dsr_q;

  // Next-state and datapath update.
  // Operands are registered on accept; the first RUN cycle (setup_q) applies
  // the zero-skip and early-exit decisions, giving one cycle of accept latency.
  always_comb begin
    state_d = state_q;
    setup_d = setup_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          setup_d = 1'b1;
          dvd_d   = a;
          dsr_d   = b;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
        end
      end
      RUN: begin
        if (setup_q) begin
          setup_d = 1'b0;
          dvd_d   = dvd_q << lz;
          cnt_d   = lz;
          rem_d   = '0;
          quo_d   = '0;
          if (dsr_q == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = dvd_q;
          end else if (lz == CW'(WIDTH)) begin
            state_d = DONE;
          end
        end else begin
          rem_d = take ? diff : trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], take};
          dvd_d = dvd_q << 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      setup_q <= 1'b0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      setup_q <= setup_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign finish      = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign q           = quo_q;
  assign r           = rem_q;
  assign div_by_zero = dbz_q;
  assign counter     = cnt_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: instance 0 uses zero-skip, instance 1 is
// constant-time. A behavioural model supplies per-cycle expectations.
module tb_seq_divider;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv   [2];
  logic       ordy [2];
  logic [7:0] a_s  [2];
  logic [7:0] b_s  [2];
  logic       irdy [2];
  logic       ov   [2];
  logic       bsy  [2];
  logic       fin  [2];
  logic       dbz  [2];
  logic [7:0] qo   [2];
  logic [7:0] ro   [2];
  logic [3:0] cnt  [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int exp_a [2];
  int exp_b [2];
  bit exp_on [2];

  seq_divider #(.WIDTH(W), .CT_TIME(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a_s[0]), .b(b_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .q(qo[0]), .r(ro[0]), .div_by_zero(dbz[0]), .busy(bsy[0]),
    .finish(fin[0]), .counter(cnt[0])
  );

  seq_divider #(.WIDTH(W), .CT_TIME(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a_s[1]), .b(b_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .q(qo[1]), .r(ro[1]), .div_by_zero(dbz[1]), .busy(bsy[1]),
    .finish(fin[1]), .counter(cnt[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: plain integer division plus the latency rule.
  function automatic int m_q(input int x, input int y);
    return (y == 0) ? 255 : x / y;
  endfunction
  function automatic int m_r(input int x, input int y);
    return (y == 0) ? x : x % y;
  endfunction
  function automatic int m_lat(input int x, input int y, input bit ct);
    int n = 0;
    int t = x;
    if (y == 0) return 1;
    if (ct) return W + 1;
    while (t > 0) begin
      n++;
      t = t >> 1;
    end
    return (n == 0) ? 1 : n + 1;
  endfunction

  // Compare process: whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        if (ov[s]) begin
          if (!exp_on[s]) chk($sformatf("spurious_valid%0d", s), 1, 0);
          else begin
            chk($sformatf("q%0d", s), qo[s], m_q(exp_a[s], exp_b[s]));
            chk($sformatf("r%0d", s), ro[s], m_r(exp_a[s], exp_b[s]));
            chk($sformatf("dbz%0d", s), dbz[s], (exp_b[s] == 0) ? 1 : 0);
            chk($sformatf("in_ready_done%0d", s), irdy[s], 0);
            chk($sformatf("finish%0d", s), fin[s], 1);
            chk($sformatf("busy_done%0d", s), bsy[s], 1);
            if (exp_b[s] != 0) begin
              chk($sformatf("identity%0d", s),
                  int'(qo[s]) * exp_b[s] + int'(ro[s]), exp_a[s]);
              chk($sformatf("r_lt_b%0d", s), (int'(ro[s]) < exp_b[s]) ? 1 : 0, 1);
              chk($sformatf("counter_done%0d", s), cnt[s], W);
            end
          end
        end
      end
    end
  end

  task automatic check_reset(input int s);
    chk($sformatf("rst_in_ready%0d", s), irdy[s], 1);
    chk($sformatf("rst_out_valid%0d", s), ov[s], 0);
    chk($sformatf("rst_busy%0d", s), bsy[s], 0);
    chk($sformatf("rst_finish%0d", s), fin[s], 0);
    chk($sformatf("rst_q%0d", s), qo[s], 0);
    chk($sformatf("rst_r%0d", s), ro[s], 0);
    chk($sformatf("rst_dbz%0d", s), dbz[s], 0);
    chk($sformatf("rst_counter%0d", s), cnt[s], 0);
  endtask

  // One transaction with hand-computed literal expectations; bp adds three
  // cycles of backpressure with new operands offered throughout.
  task automatic do_op(input int s, input int x, input int y,
                       input int lq, input int lr, input int ld,
                       input int llat, input bit bp);
    int acc;
    int waited;
    exp_a[s]  = x;
    exp_b[s]  = y;
    exp_on[s] = 1'b1;
    chk($sformatf("ready_before%0d", s), irdy[s], 1);
    a_s[s] = 8'(x);
    b_s[s] = 8'(y);
    iv[s]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc   = cyc;
    iv[s] = 1'b0;
    chk($sformatf("busy_after_accept%0d", s), bsy[s], 1);
    waited = 0;
    while (!ov[s] && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ov[s]) chk($sformatf("timeout%0d_%0d_%0d", s, x, y), 0, 1);
    chk($sformatf("latency%0d_%0d_%0d", s, x, y), cyc - acc, llat);
    chk($sformatf("model_latency%0d_%0d_%0d", s, x, y), cyc - acc, m_lat(x, y, s == 1));
    chk($sformatf("lit_q%0d_%0d_%0d", s, x, y), qo[s], lq);
    chk($sformatf("lit_r%0d_%0d_%0d", s, x, y), ro[s], lr);
    chk($sformatf("lit_dbz%0d_%0d_%0d", s, x, y), dbz[s], ld);
    if (bp) begin
      a_s[s] = 8'd3;
      b_s[s] = 8'd1;
      iv[s]  = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("bp_in_ready%0d", s), irdy[s], 0);
        chk($sformatf("bp_valid%0d", s), ov[s], 1);
        chk($sformatf("bp_q%0d", s), qo[s], lq);
        chk($sformatf("bp_r%0d", s), ro[s], lr);
      end
    end
    ordy[s] = 1'b1;
    @(negedge clk);
    ordy[s] = 1'b0;
    chk($sformatf("accept_valid_low%0d", s), ov[s], 0);
    chk($sformatf("accept_in_ready%0d", s), irdy[s], 1);
    chk($sformatf("accept_not_busy%0d", s), bsy[s], 0);
    chk($sformatf("accept_dbz_clear%0d", s), dbz[s], 0);
    chk($sformatf("keep_q%0d", s), qo[s], lq);
    iv[s]     = 1'b0;
    exp_on[s] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ordy[s] = 1'b0; a_s[s] = '0; b_s[s] = '0; exp_on[s] = 1'b0;
      exp_a[s] = 0; exp_b[s] = 1;
    end
    repeat (2) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;
    @(negedge clk);

    // zero-skip instance
    do_op(0, 100, 7,  14, 2,   0, 8, 1'b0);
    do_op(0, 0,   5,  0,  0,   0, 1, 1'b0);
    do_op(0, 37,  0,  255, 37, 1, 1, 1'b0);
    do_op(0, 255, 1,  255, 0,  0, 9, 1'b0);
    do_op(0, 200, 201, 0, 200, 0, 9, 1'b1);
    do_op(0, 1,   1,  1,  0,   0, 2, 1'b0);
    // constant-time instance
    do_op(1, 0,   5,  0,  0,   0, 9, 1'b0);
    do_op(1, 100, 7,  14, 2,   0, 9, 1'b0);
    do_op(1, 37,  0,  255, 37, 1, 1, 1'b0);
    do_op(1, 128, 3,  42, 2,   0, 9, 1'b0);

    // asynchronous reset in the middle of RUN
    a_s[0] = 8'd100;
    b_s[0] = 8'd7;
    iv[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_mid_run", bsy[0], 1);
    #2 rst = 1'b1;
    #1 check_reset(0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(0, 9, 3, 3, 0, 0, 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
